// File: rtl/tt_um_uart_rx_fifo.sv
// tt_um_uart_rx_fifo: 8N1 UART receiver feeding a small byte FIFO.
// The FIFO head byte is shown on uo_out and the status flags on uio_out[3:0].
module tt_um_uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic              r_rx_s1, r_rx_s2, r_rx_d;
  logic [1:0]        r_settle;
  logic              r_pop_s1, r_pop_s2, r_pop_d;
  logic              r_clr_s1, r_clr_s2, r_clr_d;
  state_t            r_state;
  logic [TICK_W-1:0] r_tick;
  logic [2:0]        r_bitcnt;
  logic [7:0]        r_shift;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overrun, r_framing_err;

  logic w_rx_fall, w_pop_edge, w_clr_edge;
  logic w_stop_sample, w_push, w_frame_err;
  logic w_full, w_do_pop, w_do_push, w_ovr_set;
  logic w_unused;

  assign w_unused = &{1'b0, ena, ui_in[7:2], uio_in[7:5], uio_in[3:0]};

  // Input synchronizers and edge detectors.
  // r_settle masks the reset-forced high of the rx chain so a line that is
  // already low at reset release is not mistaken for a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_d   <= 1'b0;
      r_settle <= '0;
      r_pop_s1 <= 1'b0;
      r_pop_s2 <= 1'b0;
      r_pop_d  <= 1'b0;
      r_clr_s1 <= 1'b0;
      r_clr_s2 <= 1'b0;
      r_clr_d  <= 1'b0;
    end else begin
      r_rx_s1  <= ui_in[0];
      r_rx_s2  <= r_rx_s1;
      r_settle <= {r_settle[0], 1'b1};
      r_rx_d   <= r_settle[1] & r_rx_s2;
      r_pop_s1 <= ui_in[1];
      r_pop_s2 <= r_pop_s1;
      r_pop_d  <= r_pop_s2;
      r_clr_s1 <= uio_in[4];
      r_clr_s2 <= r_clr_s1;
      r_clr_d  <= r_clr_s2;
    end
  end

  assign w_rx_fall  = r_settle[1] & r_rx_d & ~r_rx_s2;
  assign w_pop_edge = r_pop_s2 & ~r_pop_d;
  assign w_clr_edge = r_clr_s2 & ~r_clr_d;

  // Receive FSM: start-bit qualification, LSB-first data shift, stop check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_tick   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tick <= '0;
          if (w_rx_fall) r_state <= S_START;
        end
        S_START: begin
          if (r_tick == TICK_HALF) begin
            r_tick   <= '0;
            r_bitcnt <= '0;
            r_state  <= r_rx_s2 ? S_IDLE : S_DATA;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        S_DATA: begin
          if (r_tick == TICK_LAST) begin
            r_tick   <= '0;
            r_shift  <= {r_rx_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) r_state <= S_STOP;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        S_STOP: begin
          if (r_tick == TICK_LAST) begin
            r_tick  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_stop_sample = (r_state == S_STOP) && (r_tick == TICK_LAST);
  assign w_push        = w_stop_sample & r_rx_s2;
  assign w_frame_err   = w_stop_sample & ~r_rx_s2;

  assign w_full    = (r_count == CNT_FULL);
  assign w_do_pop  = w_pop_edge && (r_count != '0);
  assign w_do_push = w_push && (!w_full || w_do_pop);
  assign w_ovr_set = w_push && w_full && !w_do_pop;

  // FIFO storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun     <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      r_overrun     <= (r_overrun & ~w_clr_edge) | w_ovr_set;
      r_framing_err <= (r_framing_err & ~w_clr_edge) | w_frame_err;
    end
  end

  assign uo_out  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign uio_out = {4'b0000, r_framing_err, r_overrun, w_full, (r_count != '0)};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_uart_rx_fifo.sv
// Bench for tt_um_uart_rx_fifo: directed frames plus a randomized frame/pop mix
// checked against a queue-based model of the receiver and FIFO.
module tb_tt_um_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         m_ovr;
  bit         m_fe;

  tt_um_uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_out();
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    return {head, 4'b0000, m_fe, m_ovr, (q.size() == DEPTH), (q.size() != 0)};
  endfunction

  task automatic model_clear();
    q.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // Drive one full 8N1 frame, then a few idle cycles, and update the model.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    ui_in[0] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ui_in[0] = d[i];
      repeat (CPB) @(negedge clk);
    end
    ui_in[0] = stop_ok;
    repeat (CPB) @(negedge clk);
    ui_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    if (!stop_ok) m_fe = 1'b1;
    else if (q.size() < DEPTH) q.push_back(d);
    else m_ovr = 1'b1;
  endtask

  task automatic do_pop();
    ui_in[1] = 1'b1;
    repeat (3) @(negedge clk);
    ui_in[1] = 1'b0;
    repeat (4) @(negedge clk);
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic do_clr();
    uio_in[4] = 1'b1;
    repeat (2) @(negedge clk);
    uio_in[4] = 1'b0;
    repeat (4) @(negedge clk);
    m_ovr = 1'b0;
    m_fe  = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i % 10 == 9) begin
        n_checks++;
        if ({uo_out, uio_out, uio_oe} !== 24'h00000F) begin
          n_fail++;
          $display("FAIL reset_idle cyc%0d: got %h expected 00000f", i, {uo_out, uio_out, uio_oe});
        end
      end
    end
  endtask

  task automatic test_single();
    int lat;
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (lat < 300 && uio_out[0] !== 1'b1) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    // Start edge lands 3 cycles after the line falls; stop sample at 9.5 bit times later.
    n_checks++;
    if (lat < CPB * 19 / 2 + 2 || lat > CPB * 19 / 2 + 4) begin
      n_fail++;
      $display("FAIL single_latency: got %0d cycles expected %0d..%0d", lat, CPB * 19 / 2 + 2, CPB * 19 / 2 + 4);
    end
    n_checks++;
    if ({uo_out, uio_out} !== 16'hA501) begin
      n_fail++;
      $display("FAIL single_rx: got %h expected a501", {uo_out, uio_out});
    end
    do_pop();
    n_checks++;
    if ({uo_out, uio_out} !== 16'h0000) begin
      n_fail++;
      $display("FAIL single_pop: got %h expected 0000", {uo_out, uio_out});
    end
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [5];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      send_frame(bytes[i], 1'b1);
      if (i == 3) begin
        n_checks++;
        if (uio_out !== 8'h03) begin
          n_fail++;
          $display("FAIL ovf_full: got %h expected 03", uio_out);
        end
      end
    end
    n_checks++;
    if ({uo_out, uio_out} !== 16'h1107) begin
      n_fail++;
      $display("FAIL ovf_overrun: got %h expected 1107", {uo_out, uio_out});
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (uo_out !== ((i < 4) ? bytes[i] : 8'h00)) begin
        n_fail++;
        $display("FAIL ovf_pop%0d: got %h expected %h", i, uo_out, (i < 4) ? bytes[i] : 8'h00);
      end
      do_pop();
    end
    n_checks++;
    if ({uo_out, uio_out} !== 16'h0004) begin
      n_fail++;
      $display("FAIL ovf_drained: got %h expected 0004", {uo_out, uio_out});
    end
    do_clr();
    n_checks++;
    if (uio_out !== 8'h00) begin
      n_fail++;
      $display("FAIL ovf_clr: got %h expected 00", uio_out);
    end
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0);
    n_checks++;
    if ({uo_out, uio_out} !== 16'h0008) begin
      n_fail++;
      $display("FAIL frame_err: got %h expected 0008", {uo_out, uio_out});
    end
    do_clr();
    n_checks++;
    if (uio_out !== 8'h00) begin
      n_fail++;
      $display("FAIL frame_clr: got %h expected 00", uio_out);
    end
  endtask

  task automatic test_glitch();
    ui_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    ui_in[0] = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    n_checks++;
    if ({uo_out, uio_out} !== 16'h0000) begin
      n_fail++;
      $display("FAIL glitch_ignored: got %h expected 0000", {uo_out, uio_out});
    end
    send_frame(8'h7E, 1'b1);
    n_checks++;
    if ({uo_out, uio_out} !== 16'h7E01) begin
      n_fail++;
      $display("FAIL glitch_next: got %h expected 7e01", {uo_out, uio_out});
    end
    do_pop();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'hFF;
    ui_in[0] = 1'b0;
    repeat (CPB) @(negedge clk);
    ui_in[0] = d[0];
    repeat (4 * CPB + 8) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    ui_in[0] = 1'b1;
    rst_n = 1'b1;
    model_clear();
    repeat (8 * CPB) @(negedge clk);
    n_checks++;
    if ({uo_out, uio_out} !== 16'h0000) begin
      n_fail++;
      $display("FAIL midframe_reset: got %h expected 0000", {uo_out, uio_out});
    end
    send_frame(8'h81, 1'b1);
    n_checks++;
    if ({uo_out, uio_out} !== 16'h8101) begin
      n_fail++;
      $display("FAIL midframe_next: got %h expected 8101", {uo_out, uio_out});
    end
    do_pop();
  endtask

  task automatic test_rx_low_at_release();
    ui_in[0] = 1'b0;
    apply_reset();
    repeat (12 * CPB) @(negedge clk);
    ui_in[0] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    n_checks++;
    if ({uo_out, uio_out} !== 16'h0000) begin
      n_fail++;
      $display("FAIL rx_low_release: got %h expected 0000", {uo_out, uio_out});
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit ok;
    for (int i = 0; i < 18; i++) begin
      d  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_frame(d, ok);
      n_checks++;
      if ({uo_out, uio_out} !== exp_out()) begin
        n_fail++;
        $display("FAIL random_rx%0d: got %h expected %h", i, {uo_out, uio_out}, exp_out());
      end
      if ($urandom_range(0, 2) == 0) begin
        do_pop();
        n_checks++;
        if ({uo_out, uio_out} !== exp_out()) begin
          n_fail++;
          $display("FAIL random_pop%0d: got %h expected %h", i, {uo_out, uio_out}, exp_out());
        end
      end
      if (i % 6 == 5) do_clr();
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      do_pop();
      n_checks++;
      if ({uo_out, uio_out} !== exp_out()) begin
        n_fail++;
        $display("FAIL random_drain%0d: got %h expected %h", i, {uo_out, uio_out}, exp_out());
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h01;
    uio_in = 8'h00;
    model_clear();
    test_reset();
    test_single();
    test_overflow();
    test_framing();
    test_glitch();
    test_reset_midframe();
    test_rx_low_at_release();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
